mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Two-port arbiter that shares the single main memory between the CPU and a DMA/program-loader requester.
- Sits between the requesters and the memory:
  - 8-bit address.
  - 8-bit write data.
  - 16-bit read data.
  - Single write-enable.
- Grants ownership round-robin, with a bounded hold time.
- Registers read data back to the requester that owns the memory.

Parameters:
- AW, 8, memory address width.
- DW, 8, write data width.
- RW, 16, read data width.
- MAX_HOLD, 4, max consecutive owned cycles before a forced handover when the other side is requesting (range 1..15).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cpu_req  input  1  CPU requests a memory access this cycle.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  AW  CPU address.
- cpu_wdata  input  DW  CPU write data.
- cpu_gnt  output  1  CPU owns memory this cycle.
- cpu_rvalid  output  1  cpu_rdata valid (1-cycle pulse).
- cpu_rdata  output  RW  registered read data.
- dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata: same as the cpu_* ports, for the DMA side.
- mem_we  output  1  memory write enable (MW).
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  RW  memory read data, combinational from mem_addr.

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, last_owner=DMA, hold_cnt=0.
  - All gnt/rvalid = 0; rdata = 0.
  - mem_we = 0; mem_addr = 0; mem_wdata = 0.
  - Reset mid-transaction discards any pending read; no rvalid follows.
- States: IDLE, OWN_CPU, OWN_DMA. The gnt outputs decode the state register directly:
  - cpu_gnt = (state==OWN_CPU).
  - dma_gnt = (state==OWN_DMA).
- IDLE:
  - Only one side requesting -> go to that side's OWN state.
  - Both requesting -> grant the side that is not last_owner (round-robin).
  - Neither requesting -> stay in IDLE.
- Grant latency: req seen at edge N -> gnt high from cycle N+1.
- Transaction: an access occurs in every cycle where gnt_x and req_x are both high.
  - Requester holds req/we/addr/wdata stable until it sees gnt.
- OWN_x, each cycle:
  - req_x=0:
    - Other side requesting -> go to OWN_other.
    - Otherwise -> go to IDLE.
  - req_x=1 and other side requesting and hold_cnt==MAX_HOLD-1 -> go to OWN_other (forced handover).
  - Otherwise -> stay in OWN_x and increment hold_cnt, saturating at MAX_HOLD-1.
  - hold_cnt clears on every state change.
  - last_owner updates to x on entry to OWN_x.
- Handover is direct, with no idle cycle between owners; gnt is never high on both sides.
- Memory mux:
  - OWN_x and req_x: mem_addr=addr_x, mem_wdata=wdata_x, mem_we=we_x.
  - Any other cycle: mem_we=0, mem_addr=0, mem_wdata=0.
  - mem_we is never high without the corresponding gnt.
- Read return:
  - Granted read at cycle N -> rdata_x <= mem_rdata at edge N+1.
  - rvalid_x is a 1-cycle pulse at N+1.
  - Back-to-back reads give rvalid every cycle.
  - Writes never produce rvalid.
  - rdata holds its last value when rvalid=0.

Optional Feature:
- Macro: MEM_ARB_CPU_PRIO_EN.
- Defined:
  - Fixed priority; CPU wins all IDLE ties, and last_owner is ignored.
  - The DMA hold limit is 1 cycle while cpu_req=1.
  - The CPU hold limit is unbounded (no forced handover from CPU).
- Undefined: round-robin with symmetric MAX_HOLD, as specified above.

Decomposition:
- Shared package mem_pkg:
  - Owner/state encoding typedef (IDLE=2'b00, OWN_CPU=2'b01, OWN_DMA=2'b10).
  - AW, DW and RW default constants.
- One sub-module, arb_hold_counter: saturating hold counter with clear and limit-reached flag.
- The FSM, memory mux and read-return registers stay in mem_arbiter.

Test Plan:
- Reset: rst high for 2 cycles while both req=1 -> all gnt=0, mem_we=0, rvalid=0; after release, cpu_gnt=1 on the first cycle after rst deasserts.
- Single CPU read: cpu_req=1, we=0, addr=8'h10, mem_rdata model=16'hBEEF -> cpu_gnt next cycle, mem_addr=8'h10; cpu_rvalid one cycle later with cpu_rdata=16'hBEEF; dma_rvalid stays 0.
- DMA write: dma_req=1, we=1, addr=8'h20, wdata=8'h5A -> mem_we=1, mem_addr=8'h20, mem_wdata=8'h5A for exactly the granted cycle; no rvalid.
- Contention, MAX_HOLD=4, both req held high -> grants alternate CPU x4, DMA x4, CPU x4; never both gnt; no gap cycle at handover.
- Owner drops req mid-hold (CPU releases after 2 cycles, DMA waiting) -> dma_gnt on the next cycle; hold_cnt restarts at 0.
- MEM_ARB_CPU_PRIO_EN defined, both req high from IDLE -> CPU granted and keeps the grant indefinitely; DMA granted only after cpu_req drops, and preempted 1 cycle after cpu_req rises again.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default widths for the CPU/DMA memory arbiter.
// Holds the owner/state encoding used by the FSM and the hold counter.
package mem_pkg;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 8;
    localparam int MEM_RW = 16;

    // Wide enough for MAX_HOLD up to 15
    localparam int HOLD_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        OWN_CPU = 2'b01,
        OWN_DMA = 2'b10
    } state_t;

endpackage

// File: rtl/arb_hold_counter.sv
// Saturating count of consecutive owned cycles for the memory arbiter.
// Ports: clk, rst, clr (state change), inc (owner kept), limit, cnt, at_limit.
module arb_hold_counter
    import mem_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [HOLD_W-1:0] limit,
    output logic [HOLD_W-1:0] cnt,
    output logic              at_limit
);

    localparam logic [HOLD_W-1:0] SAT = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] ONE = HOLD_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt < SAT)) begin
            cnt <= cnt + ONE;
        end
    end

    // Current cycle is the last one the owner may keep under contention
    assign at_limit = (cnt >= (limit - ONE));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port CPU/DMA arbiter for the single main memory: round-robin with
// bounded hold, direct handover, registered read return per requester.
// Ports: clk, rst (sync, active high), cpu_*/dma_* requester buses,
// mem_we/mem_addr/mem_wdata to memory, mem_rdata (combinational) back.
// Build option MEM_ARB_CPU_PRIO_EN: CPU fixed priority, unbounded CPU
// hold, DMA limited to one cycle while the CPU is requesting.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW       = MEM_AW,
    parameter int DW       = MEM_DW,
    parameter int RW       = MEM_RW,
    parameter int MAX_HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [RW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_gnt,
    output logic          dma_rvalid,
    output logic [RW-1:0] dma_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [RW-1:0] mem_rdata
);

    state_t            state;
    state_t            state_nx;
    state_t            last_owner;
    state_t            tie_win;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_limit;
    logic              at_limit;
    logic              force_cpu;
    logic              force_dma;
    logic              changing;
    logic              cpu_acc;
    logic              dma_acc;

`ifdef MEM_ARB_CPU_PRIO_EN
    assign tie_win    = OWN_CPU;
    assign hold_limit = HOLD_W'(1);
    assign force_cpu  = 1'b0;
    assign force_dma  = at_limit;
`else
    assign tie_win    = (last_owner == OWN_CPU) ? OWN_DMA : OWN_CPU;
    assign hold_limit = HOLD_W'(MAX_HOLD);
    assign force_cpu  = at_limit;
    assign force_dma  = at_limit;
`endif

    assign changing = (state_nx != state);

    arb_hold_counter #(
        .MAX_HOLD (MAX_HOLD)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .clr      (changing),
        .inc      (state != IDLE),
        .limit    (hold_limit),
        .cnt      (hold_cnt),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWN_DMA;
        end else begin
            state <= state_nx;
            if (state_nx != IDLE) begin
                last_owner <= state_nx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (cpu_req && dma_req) begin
                    state_nx = tie_win;
                end else if (cpu_req) begin
                    state_nx = OWN_CPU;
                end else if (dma_req) begin
                    state_nx = OWN_DMA;
                end
            end
            OWN_CPU: begin
                if (!cpu_req) begin
                    state_nx = dma_req ? OWN_DMA : IDLE;
                end else if (dma_req && force_cpu) begin
                    state_nx = OWN_DMA;
                end
            end
            OWN_DMA: begin
                if (!dma_req) begin
                    state_nx = cpu_req ? OWN_CPU : IDLE;
                end else if (cpu_req && force_dma) begin
                    state_nx = OWN_CPU;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign cpu_acc = (state == OWN_CPU) && cpu_req;
    assign dma_acc = (state == OWN_DMA) && dma_req;

    always_comb begin
        cpu_gnt   = (state == OWN_CPU);
        dma_gnt   = (state == OWN_DMA);
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            cpu_acc: begin
                mem_we    = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
            end
            dma_acc: begin
                mem_we    = dma_we;
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            cpu_rvalid <= cpu_acc && !cpu_we;
            dma_rvalid <= dma_acc && !dma_we;
            if (cpu_acc && !cpu_we) begin
                cpu_rdata <= mem_rdata;
            end
            if (dma_acc && !dma_we) begin
                dma_rdata <= mem_rdata;
            end
        end
    end

endmodule
